// File: rtl/hwag_sync_ctrl.sv
// Crank-wheel synchronisation controller: measures tooth periods, detects the
// missing-tooth gap and tracks the tooth index once the wheel pattern is locked.
module hwag_sync_ctrl #(
    parameter int PCNT_WIDTH = 24,
    parameter int TCNT_WIDTH = 8,
    parameter int TEETH      = 58,
    parameter int GAP_SHIFT  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  tick,
    input  logic                  cap,
    output logic [PCNT_WIDTH-1:0] period_last,
    output logic [PCNT_WIDTH-1:0] period_prev,
    output logic [TCNT_WIDTH-1:0] tooth_num,
    output logic                  synced,
    output logic                  gap_strb,
    output logic                  err_strb,
    output logic                  stall_strb,
    output logic [2:0]            state_dbg
);
    // tick and cap are single-cycle strobes sampled on every clk edge; there is
    // no backpressure, every cap seen outside IDLE is acted upon in that cycle.

    typedef enum logic [2:0] {IDLE, WAIT1, WAIT2, SEARCH, SYNC} state_t;

    localparam int XW = PCNT_WIDTH + GAP_SHIFT;
    localparam logic [PCNT_WIDTH-1:0] PCNT_MAX   = '1;
    localparam logic [TCNT_WIDTH-1:0] LAST_TOOTH = TCNT_WIDTH'(TEETH - 1);

    state_t                state, state_nx;
    logic [PCNT_WIDTH-1:0] pcnt, pcnt_nx, last_nx, prev_nx, pcnt_reload;
    logic [TCNT_WIDTH-1:0] tooth_nx;
    logic                  gap_nx, err_nx, stall_nx;
    logic [XW-1:0]         cap_ext, lim_ext;
    logic                  is_gap, pcnt_sat;

    // Widened compare so the shifted previous period cannot overflow.
    assign cap_ext     = XW'(pcnt);
    assign lim_ext     = XW'(period_last) << GAP_SHIFT;
    assign is_gap      = cap_ext > lim_ext;
    assign pcnt_sat    = (pcnt == PCNT_MAX);
    assign pcnt_reload = {{(PCNT_WIDTH-1){1'b0}}, tick};
    assign state_dbg   = state;

    always_comb begin
        state_nx = state;
        pcnt_nx  = pcnt;
        last_nx  = period_last;
        prev_nx  = period_prev;
        tooth_nx = tooth_num;
        gap_nx   = 1'b0;
        err_nx   = 1'b0;
        stall_nx = 1'b0;

        if (!en) begin
            state_nx = IDLE;
            pcnt_nx  = '0;
            last_nx  = '0;
            prev_nx  = '0;
            tooth_nx = '0;
        end else begin
            if (state != IDLE && tick && !pcnt_sat) begin
                pcnt_nx = pcnt + 1'b1;
            end
            case (state)
                IDLE: state_nx = WAIT1;
                WAIT1: begin
                    if (cap) begin
                        pcnt_nx  = pcnt_reload;
                        state_nx = WAIT2;
                    end
                end
                default: begin
                    if (cap) begin
                        pcnt_nx = pcnt_reload;
                        prev_nx = period_last;
                        last_nx = pcnt;
                        if (state == WAIT2) begin
                            state_nx = SEARCH;
                        end else if (state == SEARCH) begin
                            tooth_nx = '0;
                            if (is_gap) begin
                                gap_nx   = 1'b1;
                                state_nx = SYNC;
                            end
                        end else if (is_gap && tooth_num == LAST_TOOTH) begin
                            gap_nx   = 1'b1;
                            tooth_nx = '0;
                        end else if (is_gap || tooth_num == LAST_TOOTH) begin
                            // Early or missing gap: the wheel pattern no longer matches.
                            err_nx   = 1'b1;
                            tooth_nx = '0;
                            state_nx = SEARCH;
                        end else begin
                            tooth_nx = tooth_num + 1'b1;
                        end
                    end else if (pcnt_sat) begin
                        stall_nx = 1'b1;
                        tooth_nx = '0;
                        pcnt_nx  = '0;
                        state_nx = WAIT1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pcnt        <= '0;
            period_last <= '0;
            period_prev <= '0;
            tooth_num   <= '0;
            synced      <= 1'b0;
            gap_strb    <= 1'b0;
            err_strb    <= 1'b0;
            stall_strb  <= 1'b0;
        end else begin
            state       <= state_nx;
            pcnt        <= pcnt_nx;
            period_last <= last_nx;
            period_prev <= prev_nx;
            tooth_num   <= tooth_nx;
            synced      <= (state_nx == SYNC);
            gap_strb    <= gap_nx;
            err_strb    <= err_nx;
            stall_strb  <= stall_nx;
        end
    end
endmodule

// File: tb/tb_hwag_sync_ctrl.sv
// Bench for hwag_sync_ctrl: directed wheel patterns plus randomized teeth,
// checked cycle by cycle against a tooth-level reference model.
module tb_hwag_sync_ctrl;
    localparam int PW    = 8;
    localparam int TW    = 8;
    localparam int TEETH = 4;
    localparam int GS    = 1;
    localparam int PMAX  = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst, en, tick, cap;
    logic [PW-1:0] period_last, period_prev;
    logic [TW-1:0] tooth_num;
    logic          synced, gap_strb, err_strb, stall_strb;
    logic [2:0]    state_dbg;

    hwag_sync_ctrl #(
        .PCNT_WIDTH(PW), .TCNT_WIDTH(TW), .TEETH(TEETH), .GAP_SHIFT(GS)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .tick(tick), .cap(cap),
        .period_last(period_last), .period_prev(period_prev),
        .tooth_num(tooth_num), .synced(synced), .gap_strb(gap_strb),
        .err_strb(err_strb), .stall_strb(stall_strb), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: m_idle = the one enabled cycle spent leaving idle,
    // m_caps = edges seen since (re)start (0 none, 1 armed, 2+ periods valid).
    bit m_idle, m_sync, e_gap, e_err, e_stall;
    int m_caps, m_tooth, m_last, m_prev, m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_idle = 1; m_sync = 0; m_caps = 0; m_tooth = 0;
        m_last = 0; m_prev = 0; m_cnt = 0;
    endtask

    task automatic check_all();
        chk("period_last", 32'(period_last), 32'(m_last));
        chk("period_prev", 32'(period_prev), 32'(m_prev));
        chk("tooth_num",   32'(tooth_num),   32'(m_tooth));
        chk("synced",      32'(synced),      32'(m_sync));
        chk("gap_strb",    32'(gap_strb),    32'(e_gap));
        chk("err_strb",    32'(err_strb),    32'(e_err));
        chk("stall_strb",  32'(stall_strb),  32'(e_stall));
    endtask

    task automatic step(input bit en_v, input bit cap_v, input bit tick_v);
        int  c;
        bit  g;
        @(negedge clk);
        en = en_v; cap = cap_v; tick = tick_v;
        e_gap = 0; e_err = 0; e_stall = 0;
        if (!en_v) begin
            model_clear();
        end else if (m_idle) begin
            m_idle = 0;
        end else if (cap_v) begin
            c = m_cnt;
            if (m_caps == 0) begin
                m_caps = 1;
            end else begin
                g = c > (m_last << GS);
                m_prev = m_last;
                m_last = c;
                if (m_caps == 1) begin
                    m_caps = 2;
                end else if (!m_sync) begin
                    if (g) begin m_sync = 1; m_tooth = 0; e_gap = 1; end
                end else if (g && m_tooth == TEETH - 1) begin
                    e_gap = 1; m_tooth = 0;
                end else if (g || m_tooth == TEETH - 1) begin
                    e_err = 1; m_sync = 0; m_tooth = 0;
                end else begin
                    m_tooth++;
                end
            end
            m_cnt = tick_v;
        end else if (m_caps > 0 && m_cnt == PMAX) begin
            e_stall = 1; m_caps = 0; m_sync = 0; m_tooth = 0; m_cnt = 0;
        end else begin
            m_cnt = (m_cnt + tick_v > PMAX) ? PMAX : m_cnt + tick_v;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    // One tooth interval of n clocks ending with the cap strobe.
    task automatic tooth(input int n, input bit rnd_tick);
        for (int i = 0; i < n; i++) begin
            step(1, i == n - 1, rnd_tick ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    endtask

    initial begin
        int r, n;
        rst = 1; en = 1; tick = 1; cap = 0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        e_gap = 0; e_err = 0; e_stall = 0;
        check_all();
        @(negedge clk);
        rst = 0;

        // Saturation while waiting for the first edge must not stall; after it must.
        repeat (300) step(1, 0, 1);
        step(1, 1, 1);
        repeat (260) step(1, 0, 1);

        // Lock onto the wheel and run two clean revolutions.
        tooth(10, 0); tooth(10, 0); tooth(10, 0); tooth(30, 0);
        repeat (2) begin
            repeat (TEETH - 1) tooth(10, 0);
            tooth(30, 0);
        end

        // Early gap after tooth 1, then resync on the next gap.
        tooth(10, 0); tooth(30, 0);
        repeat (TEETH - 1) tooth(10, 0);
        tooth(30, 0);

        // Missing gap after tooth 3, then resync.
        repeat (TEETH - 1) tooth(10, 0);
        tooth(10, 0); tooth(30, 0);

        // Drop enable at tooth 2, restart, and probe the exact 2x boundary.
        tooth(10, 0); tooth(10, 0);
        step(0, 0, 1);
        step(1, 0, 1);
        tooth(10, 0); tooth(10, 0); tooth(20, 0); tooth(10, 0); tooth(21, 0);
        repeat (TEETH - 1) tooth(10, 0);
        tooth(30, 0);

        // Randomized teeth, gaps, tick gating and enable drops.
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                repeat ($urandom_range(1, 3)) step(0, $urandom_range(0, 1) != 0, 1);
            end else begin
                if (m_sync && m_tooth == TEETH - 1 && r < 17) n = $urandom_range(35, 60);
                else if (r >= 18) n = $urandom_range(30, 60);
                else n = $urandom_range(1, 15);
                tooth(n, 1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
